// File: rtl/input_descaler_if.sv
// input_descaler_if: ADC word, GPIO config bus and descaled value output bundle.
interface input_descaler_if #(parameter int W = 8);
    logic [255:0] adc_word;
    logic         adc_word_valid;
    logic [31:0]  gpio;
    logic [W-1:0] val;
    logic         val_valid;
    modport master (output adc_word, adc_word_valid, gpio, input val, val_valid);
    modport slave (input adc_word, adc_word_valid, gpio, output val, val_valid);
endinterface

// File: rtl/input_descaler.sv
// input_descaler: recovers a spin amplitude from 16-lane ADC words via lane sums, group averaging and scaling.
package ising_config;
    parameter int num_bits = 8;
endpackage

module input_descaler
    import ising_config::*;
#(
    parameter logic [15:0] cfg_base = 16'h0100
) (
    input logic clk,
    input logic rst,
    input_descaler_if.slave bus
);
    typedef enum logic {ACCUM, DUMP} state_t;
    localparam logic signed [24:0] vmax = 25'((1 << num_bits) - 1);

    state_t state;
    logic wclk_q, wr, wr_avg, s1_v, r_v, val_v, dump;
    logic signed [18:0] pos_c, neg_c, pos_q, neg_q;
    logic signed [19:0] diff;
    logic signed [23:0] acc, acc_n, acc_sum, res, scaled;
    logic signed [24:0] sum;
    logic signed [7:0] offset;
    logic [4:0] shift;
    logic [1:0] avg, r_avg;
    logic [2:0] cnt, cnt_n, last;
    logic [5:0] shamt;
    logic [num_bits-1:0] val_q, sat;

    assign wr = bus.gpio[24] & ~wclk_q;
    assign wr_avg = wr && bus.gpio[15:0] == cfg_base + 16'd2;
    assign bus.val = val_q;
    assign bus.val_valid = val_v;

    always_comb begin
        pos_c = '0;
        neg_c = '0;
        for (int k = 0; k < 8; k++) begin
            pos_c = pos_c + 19'(signed'(bus.adc_word[16*(k+8) +: 16]));
            neg_c = neg_c + 19'(signed'(bus.adc_word[16*k +: 16]));
        end
    end

    // A group-length write discards the partial group, including any frame waiting in stage 1.
    always_comb begin
        last = 3'((4'd1 << avg) - 4'd1);
        state = (cnt == last) ? DUMP : ACCUM;
        diff = 20'(pos_q) - 20'(neg_q);
        acc_sum = acc + 24'(diff);
        dump = s1_v && !wr_avg && state == DUMP;
        acc_n = (wr_avg || dump) ? '0 : s1_v ? acc_sum : acc;
        cnt_n = (wr_avg || dump) ? '0 : s1_v ? cnt + 3'd1 : cnt;
        shamt = 6'(shift) + 6'(r_avg);
        scaled = res >>> shamt;
        sum = 25'(scaled) + 25'(offset);
        sat = sum[24] ? '0 : (sum > vmax) ? {num_bits{1'b1}} : sum[num_bits-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wclk_q <= 1'b0;
            s1_v <= 1'b0;
            pos_q <= '0;
            neg_q <= '0;
            acc <= '0;
            cnt <= '0;
            res <= '0;
            r_avg <= '0;
            r_v <= 1'b0;
            val_q <= '0;
            val_v <= 1'b0;
            shift <= 5'd4;
            offset <= '0;
            avg <= '0;
        end else begin
            wclk_q <= bus.gpio[24];
            s1_v <= bus.adc_word_valid;
            if (bus.adc_word_valid) begin
                pos_q <= pos_c;
                neg_q <= neg_c;
            end
            acc <= acc_n;
            cnt <= cnt_n;
            r_v <= dump;
            if (dump) begin
                res <= acc_sum;
                r_avg <= avg;
            end
            val_v <= r_v;
            if (r_v) val_q <= sat;
            if (wr && bus.gpio[15:0] == cfg_base) shift <= bus.gpio[20:16];
            if (wr && bus.gpio[15:0] == cfg_base + 16'd1) offset <= bus.gpio[23:16];
            if (wr_avg) avg <= bus.gpio[17:16];
        end
    end
endmodule
